mem_wb_dump: RTL and testbench

MEM_WB_DUMP -- requirements
Module: mem_wb_dump

---
 rtl/mem_wb_dump.sv | 148 ++++++++++++++
 tb/tb_mem_wb_dump.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_dump.sv
// MEM/WB snapshot dumper: captures the five MEM/WB latch words on a start request
// and streams them byte by byte (word order ctrl..instr, LSB first) to a UART transmitter.
module mem_wb_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_pc_next,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_alu,
    input  logic [DATA_WIDTH-1:0] i_instr,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BPW = DATA_WIDTH / NB_BYTE;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(BPW - 1);
    localparam logic [2:0]    WORD_LAST = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Word 0 (least significant slot) is ctrl, word 4 is instr.
    typedef logic [4:0][DATA_WIDTH-1:0] snap_t;

    function automatic logic [NB_BYTE-1:0] pick_byte(
        input snap_t          snap,
        input logic [2:0]     word_idx,
        input logic [BW-1:0]  byte_idx
    );
        logic [DATA_WIDTH-1:0] w;
        w = snap[word_idx] >> (int'(byte_idx) * NB_BYTE);
        return w[NB_BYTE-1:0];
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    snap_t               snap_r;
    snap_t               snap_next_s;
    logic [2:0]          word_r;
    logic [2:0]          word_next_s;
    logic [BW-1:0]       byte_r;
    logic [BW-1:0]       byte_next_s;
    logic [NB_BYTE-1:0]  tx_data_r;
    logic [NB_BYTE-1:0]  tx_data_next_s;
    logic                tx_start_r;
    logic                busy_r;
    logic                done_r;
    logic                last_byte_s;

    assign last_byte_s = (word_r == WORD_LAST) && (byte_r == BYTE_LAST);

    // Next-state, counter and snapshot logic.
    always_comb begin
        state_next_s = state_r;
        word_next_s  = word_r;
        byte_next_s  = byte_r;
        snap_next_s  = snap_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    snap_next_s  = {i_instr, i_alu, i_data, i_pc_next, i_ctrl};
                    word_next_s  = 3'd0;
                    byte_next_s  = {BW{1'b0}};
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (last_byte_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = SEND;
                        if (byte_r == BYTE_LAST) begin
                            byte_next_s = {BW{1'b0}};
                            word_next_s = word_r + 3'd1;
                        end else begin
                            byte_next_s = byte_r + BW'(1);
                        end
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Outgoing byte is loaded on entry to SEND and held until the next SEND.
    always_comb begin
        tx_data_next_s = tx_data_r;
        if (state_next_s == SEND) begin
            tx_data_next_s = pick_byte(snap_next_s, word_next_s, byte_next_s);
        end else begin
            tx_data_next_s = tx_data_r;
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            snap_r     <= {(5 * DATA_WIDTH){1'b0}};
            word_r     <= 3'd0;
            byte_r     <= {BW{1'b0}};
            tx_data_r  <= {NB_BYTE{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            snap_r     <= snap_next_s;
            word_r     <= word_next_s;
            byte_r     <= byte_next_s;
            tx_data_r  <= tx_data_next_s;
            tx_start_r <= (state_next_s == SEND);
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_next_s == DONE);
        end
    end

    assign o_tx_data  = tx_data_r;
    assign o_tx_start = tx_start_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_mem_wb_dump.sv
// Directed/randomized bench for mem_wb_dump: acts as the UART transmitter and
// compares the streamed bytes against a byte list built from the captured words.
module tb_mem_wb_dump;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_ctrl, i_pc_next, i_data, i_alu, i_instr;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] wv [5];
    logic [7:0]  got_q [$];
    bit          stable;
    bit          busy_ok;

    always #5 clk = ~clk;

    mem_wb_dump #(.DATA_WIDTH(32), .NB_BYTE(8)) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_ctrl    (i_ctrl),
        .i_pc_next (i_pc_next),
        .i_data    (i_data),
        .i_alu     (i_alu),
        .i_instr   (i_instr),
        .o_tx_data (o_tx_data),
        .o_tx_start(o_tx_start),
        .i_tx_done (i_tx_done),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_words();
        i_ctrl    = wv[0];
        i_pc_next = wv[1];
        i_data    = wv[2];
        i_alu     = wv[3];
        i_instr   = wv[4];
    endtask

    task automatic set_basic_words();
        wv[0] = 32'h0000_0011;
        wv[1] = 32'h0000_0104;
        wv[2] = 32'hDEAD_BEEF;
        wv[3] = 32'h1234_5678;
        wv[4] = 32'h00A3_0333;
    endtask

    // Reference: 5 words, each emitted least-significant byte first.
    task automatic check_bytes(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        int idx;
        idx = 0;
        chk({tag, "_count"}, 32'(got_q.size()), 32'd20);
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                e = 8'(wv[w] >> (8 * b));
                g = (idx < got_q.size()) ? got_q[idx] : 8'hxx;
                chk($sformatf("%s_b%0d", tag, idx), {24'd0, g}, {24'd0, e});
                idx++;
            end
        end
    endtask

    // Transmitter model: records bytes, acks after 'delay' cycles, ends at o_done.
    task automatic serve(input int delay, input int restart_at, input bit spurious,
                         input bit corrupt, input bit hold_start, input int stop_acks,
                         output int n_done);
        int cnt;
        int acks;
        bit pending;
        logic [7:0] hold;
        got_q.delete();
        stable  = 1'b1;
        busy_ok = 1'b1;
        n_done  = 0;
        pending = 1'b0;
        cnt     = 0;
        acks    = 0;
        hold    = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_tx_done = 1'b0;
            if (!hold_start) i_start = 1'b0;
            if (corrupt && cyc == 1) begin
                i_ctrl = 32'hFFFF_FFFF; i_pc_next = 32'hFFFF_FFFF; i_data = 32'hFFFF_FFFF;
                i_alu  = 32'hFFFF_FFFF; i_instr   = 32'hFFFF_FFFF;
            end
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (o_tx_start === 1'b1) begin
                got_q.push_back(o_tx_data);
                pending = 1'b1;
                cnt     = 0;
                hold    = o_tx_data;
                if (spurious) i_tx_done = 1'b1;
                if (restart_at >= 0 && got_q.size() == restart_at) i_start = 1'b1;
            end else if (pending) begin
                if (o_tx_data !== hold) stable = 1'b0;
                cnt++;
                if (cnt == delay) begin
                    i_tx_done = 1'b1;
                    pending   = 1'b0;
                    acks++;
                    if (acks == stop_acks) return;
                end
            end
            if (o_done === 1'b1) begin
                n_done++;
                break;
            end
            tick();
        end
    endtask

    task automatic run_dump(input string tag, input int delay, input int restart_at,
                            input bit spurious, input bit corrupt);
        int nd;
        int extra;
        apply_words();
        i_start = 1'b1;
        tick();
        chk({tag, "_lat"}, 32'(o_tx_start), 32'd1);
        serve(delay, restart_at, spurious, corrupt, 1'b0, -1, nd);
        chk({tag, "_ndone"}, 32'(nd), 32'd1);
        check_bytes(tag);
        chk({tag, "_stable"}, 32'(stable), 32'd1);
        chk({tag, "_busy_hi"}, 32'(busy_ok), 32'd1);
        tick();
        chk({tag, "_busy_lo"}, 32'(o_busy), 32'd0);
        chk({tag, "_done_lo"}, 32'(o_done), 32'd0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_tx_start === 1'b1 || o_done === 1'b1) extra++;
        end
        chk({tag, "_quiet"}, 32'(extra), 32'd0);
        apply_words();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int cnt;
        i_rst_n = 1'b0; i_start = 1'b0; i_tx_done = 1'b0;
        i_ctrl = 32'h0; i_pc_next = 32'h0; i_data = 32'h0; i_alu = 32'h0; i_instr = 32'h0;
        #3;
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_tx_start", 32'(o_tx_start), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        tick();
        tick();

        // Release reset together with the first start request.
        set_basic_words();
        i_rst_n = 1'b1;
        run_dump("basic", 10, -1, 1'b0, 1'b0);

        run_dump("isolate", 3, -1, 1'b0, 1'b1);
        run_dump("busy_ign", 2, 5, 1'b0, 1'b0);

        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            i_tx_done = (k % 2 == 0);
            tick();
            if (o_tx_start === 1'b1 || o_busy === 1'b1) cnt++;
        end
        i_tx_done = 1'b0;
        chk("idle_spurious", 32'(cnt), 32'd0);
        run_dump("send_spur", 3, -1, 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 5; w++) wv[w] = $urandom;
            run_dump($sformatf("rand%0d", r), int'($urandom_range(1, 12)), -1, 1'b0, 1'b0);
        end

        // Abort a dump after the 7th byte has been acknowledged.
        set_basic_words();
        apply_words();
        i_start = 1'b1;
        tick();
        serve(4, -1, 1'b0, 1'b0, 1'b0, 7, nd);
        tick();
        i_tx_done = 1'b0;
        chk("pre_rst_start", 32'(o_tx_start), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_tx_data", 32'(o_tx_data), 32'd0);
        chk("arst_tx_start", 32'(o_tx_start), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_done", 32'(o_done), 32'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o_tx_start === 1'b1 || o_done === 1'b1 || o_busy === 1'b1) cnt++;
        end
        chk("post_rst_quiet", 32'(cnt), 32'd0);
        run_dump("restart", 2, -1, 1'b0, 1'b0);

        // Back-to-back with start held high.
        for (int w = 0; w < 5; w++) wv[w] = $urandom;
        apply_words();
        i_start = 1'b1;
        tick();
        chk("b2b_lat", 32'(o_tx_start), 32'd1);
        serve(2, -1, 1'b0, 1'b0, 1'b1, -1, nd);
        chk("b2b_ndone1", 32'(nd), 32'd1);
        check_bytes("b2b_first");
        tick();
        chk("b2b_gap_start", 32'(o_tx_start), 32'd0);
        chk("b2b_gap_busy", 32'(o_busy), 32'd0);
        tick();
        chk("b2b_second_start", 32'(o_tx_start), 32'd1);
        serve(1, -1, 1'b0, 1'b0, 1'b0, -1, nd);
        chk("b2b_ndone2", 32'(nd), 32'd1);
        check_bytes("b2b_second");
        tick();
        chk("b2b_busy_lo", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
